// File: rtl/seg_display_scanner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_scanner_pkg
//  Description : Shared definitions for the 4-digit 7-segment scanner:
//                digit count, anode constants, digit-index type and small
//                helpers for nibble selection, leading-zero detection and
//                anode decoding.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef SEG_SEL_W
`define SEG_SEL_W 2
`endif

package seg_display_scanner_pkg;

    localparam int         NUM_DIGITS    = 4;
    localparam logic [3:0] ANODE_ALL_OFF = 4'b1111;

    typedef logic [`SEG_SEL_W-1:0] digit_idx_t;

    localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

    // Hex nibble shown on digit d; digit 3 is the leftmost (value[15:12]).
    function automatic logic [3:0] nibble_sel(input logic [15:0] value,
                                              input digit_idx_t  d);
        logic [3:0] nib;
        case (d)
            2'd0:    nib = value[3:0];
            2'd1:    nib = value[7:4];
            2'd2:    nib = value[11:8];
            default: nib = value[15:12];
        endcase
        return nib;
    endfunction

    // A digit is a leading zero when it and every digit to its left are 0.
    // Digit 0 never qualifies so a zero value still shows a single "0".
    function automatic logic lead_zero(input logic [15:0] value,
                                       input digit_idx_t  d);
        logic lz;
        case (d)
            2'd0:    lz = 1'b0;
            2'd1:    lz = (value[15:4] == 12'h000);
            2'd2:    lz = (value[15:8] == 8'h00);
            default: lz = (value[15:12] == 4'h0);
        endcase
        return lz;
    endfunction

    // Active-low one-hot anode enable for digit d.
    function automatic logic [3:0] anode_select(input digit_idx_t d);
        return ~(4'b0001 << d);
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : scan_prescaler
//  Description : Modulo-MODULO counter (0 .. MODULO-1, then wraps to 0).
//                Exposes the next count so the parent can register outputs
//                that line up with the counter state, and a terminal-count
//                flag that is high in the cycle the count equals MODULO-1.
//  Ports       : clk, rst (sync, active-high), o_count_next, o_tc
//  Revision    : 1.0 - initial release
// ============================================================================

module scan_prescaler #(
    parameter int MODULO = 50000,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] o_count_next,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(MODULO - 1);

    logic [CNT_W-1:0] r_count;

    assign o_tc         = (r_count == c_last);
    assign o_count_next = o_tc ? '0 : r_count + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= o_count_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_scanner
//  Description : Time-multiplexes a 16-bit value onto a 4-digit common-anode
//                7-segment display. New values are captured into a shadow
//                register and only transferred to the display register at a
//                frame boundary, so a sweep never mixes old and new digits.
//                Each digit slot starts with a blanking gap (all anodes off)
//                to suppress ghosting; optional leading-zero blanking.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                load, value_in  - 1-cycle capture strobe and value
//                display_en      - 0 forces all anodes off
//                lz_blank        - 1 blanks leading zero digits
//                digit_nibble    - hex nibble {Z,Y,X,W} to the decoder
//                anode_n         - active-low digit enables (bit i = digit i)
//                frame_done      - 1-cycle pulse after the 3 -> 0 wrap
//  Revision    : 1.0 - initial release
// ============================================================================

module seg_display_scanner
    import seg_display_scanner_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic        display_en,
    input  logic        lz_blank,
    output logic [3:0]  digit_nibble,
    output logic [3:0]  anode_n,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] c_blank_end = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] w_cnt_next;
    logic             w_tc;
    logic             w_fb;
    digit_idx_t       r_digit;
    digit_idx_t       w_digit_next;
    logic [15:0]      r_shadow;
    logic [15:0]      r_disp;
    logic [15:0]      w_disp_next;
    logic             w_blank;
    logic [3:0]       w_anode_next;
    logic [3:0]       r_nibble;
    logic [3:0]       r_anode_n;
    logic             r_frame_done;

    scan_prescaler #(
        .MODULO (DIGIT_CYCLES),
        .CNT_W  (CNT_W)
    ) u_prescaler (
        .clk          (clk),
        .rst          (reset),
        .o_count_next (w_cnt_next),
        .o_tc         (w_tc)
    );

    assign w_fb         = w_tc && (r_digit == LAST_DIGIT);
    assign w_digit_next = w_tc ? digit_idx_t'(r_digit + 1'b1) : r_digit;

    // A load coinciding with the frame boundary bypasses the shadow so it is
    // shown in the frame that is just starting.
    assign w_disp_next  = w_fb ? (load ? value_in : r_shadow) : r_disp;

    // Outputs are decoded from the next state so they change on the same edge
    // as the prescaler/digit registers they describe.
    assign w_blank      = !display_en
                       || (w_cnt_next < c_blank_end)
                       || (lz_blank && lead_zero(w_disp_next, w_digit_next));

    assign w_anode_next = w_blank ? ANODE_ALL_OFF : anode_select(w_digit_next);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_digit      <= '0;
            r_shadow     <= '0;
            r_disp       <= '0;
            r_nibble     <= 4'h0;
            r_anode_n    <= ANODE_ALL_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_digit      <= w_digit_next;
            if (load) begin
                r_shadow <= value_in;
            end
            r_disp       <= w_disp_next;
            // The nibble is driven even while blanked so the decoder has
            // settled before the anode turns on.
            r_nibble     <= nibble_sel(w_disp_next, w_digit_next);
            r_anode_n    <= w_anode_next;
            r_frame_done <= w_fb;
        end
    end

    assign digit_nibble = r_nibble;
    assign anode_n      = r_anode_n;
    assign frame_done   = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seg_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_display_scanner
//  Description : Directed self-checking bench for seg_display_scanner with
//                DIGIT_CYCLES=8, BLANK_CYCLES=2. Cycle index cyc counts
//                clock cycles since the last reset edge; in cycle t the
//                prescaler is t%8 and the digit is (t/8)%4.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_seg_display_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value_in;
    logic        display_en;
    logic        lz_blank;
    logic [3:0]  digit_nibble;
    logic [3:0]  anode_n;
    logic        frame_done;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    seg_display_scanner #(
        .DIGIT_CYCLES (8),
        .BLANK_CYCLES (2),
        .CNT_W        (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .value_in     (value_in),
        .display_en   (display_en),
        .lz_blank     (lz_blank),
        .digit_nibble (digit_nibble),
        .anode_n      (anode_n),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
    endtask

    task automatic check3(input string tag, input logic [3:0] an,
                          input logic [3:0] nib, input logic fd);
        chk({tag, ".anode_n"},      anode_n,          an);
        chk({tag, ".digit_nibble"}, digit_nibble,     nib);
        chk({tag, ".frame_done"},   {3'b0, frame_done}, {3'b0, fd});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        cyc += n;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic pulse_load(input logic [15:0] v);
        load     = 1'b1;
        value_in = v;
        step(1);
        load     = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        load       = 1'b0;
        value_in   = 16'h0000;
        display_en = 1'b1;
        lz_blank   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cyc   = 0;

        // 1: reset state and free-running scan of value 0
        check3("rst",      4'b1111, 4'h0, 1'b0);
        goto(1);  check3("blank1",   4'b1111, 4'h0, 1'b0);
        goto(2);  check3("d0",       4'b1110, 4'h0, 1'b0);
        goto(10); check3("d1",       4'b1101, 4'h0, 1'b0);
        goto(18); check3("d2",       4'b1011, 4'h0, 1'b0);
        goto(26); check3("d3",       4'b0111, 4'h0, 1'b0);
        goto(31); check3("pre_fb",   4'b0111, 4'h0, 1'b0);
        goto(32); check3("fd1",      4'b1111, 4'h0, 1'b1);
        goto(33); check3("fd1_end",  4'b1111, 4'h0, 1'b0);

        // 2: mid-frame load becomes visible only in the next frame
        pulse_load(16'hA3F1);
        goto(42); check3("old_d1",   4'b1101, 4'h0, 1'b0);
        goto(63); check3("old_d3",   4'b0111, 4'h0, 1'b0);
        goto(64); check3("new_blank",4'b1111, 4'h1, 1'b1);
        goto(66); check3("a3f1_d0",  4'b1110, 4'h1, 1'b0);
        goto(74); check3("a3f1_d1",  4'b1101, 4'hF, 1'b0);
        goto(82); check3("a3f1_d2",  4'b1011, 4'h3, 1'b0);
        goto(90); check3("a3f1_d3",  4'b0111, 4'hA, 1'b0);

        // 3: two loads then a load in the fb cycle; the fb-cycle load wins
        goto(91); pulse_load(16'h1234);
        goto(93); pulse_load(16'h5678);
        goto(95); check3("fb_cyc",   4'b0111, 4'hA, 1'b0);
        pulse_load(16'h9ABC);
        check3("9abc_start", 4'b1111, 4'hC, 1'b1);
        goto(98);  check3("9abc_d0", 4'b1110, 4'hC, 1'b0);
        goto(106); check3("9abc_d1", 4'b1101, 4'hB, 1'b0);
        goto(114); check3("9abc_d2", 4'b1011, 4'hA, 1'b0);
        goto(122); check3("9abc_d3", 4'b0111, 4'h9, 1'b0);

        // 4: leading-zero blanking
        lz_blank = 1'b1;
        pulse_load(16'h0030);
        goto(128); check3("lz_start", 4'b1111, 4'h0, 1'b1);
        goto(130); check3("lz_d0",    4'b1110, 4'h0, 1'b0);
        goto(138); check3("lz_d1",    4'b1101, 4'h3, 1'b0);
        goto(146); check3("lz_d2",    4'b1111, 4'h0, 1'b0);
        goto(154); check3("lz_d3",    4'b1111, 4'h0, 1'b0);
        pulse_load(16'h0000);
        goto(162); check3("zero_d0",  4'b1110, 4'h0, 1'b0);
        goto(170); check3("zero_d1",  4'b1111, 4'h0, 1'b0);

        // 5: display_en low for 20 cycles mid-frame
        lz_blank = 1'b0;
        pulse_load(16'h1234);
        goto(192); check3("en_start", 4'b1111, 4'h4, 1'b1);
        goto(194); check3("en_d0",    4'b1110, 4'h4, 1'b0);
        display_en = 1'b0;
        goto(195); check3("dis_d0",   4'b1111, 4'h4, 1'b0);
        goto(203); check3("dis_d1",   4'b1111, 4'h3, 1'b0);
        goto(214); check3("dis_last", 4'b1111, 4'h2, 1'b0);
        display_en = 1'b1;
        goto(215); check3("reen_d2",  4'b1011, 4'h2, 1'b0);
        goto(223); check3("reen_d3",  4'b0111, 4'h1, 1'b0);
        goto(224); check3("en_fd",    4'b1111, 4'h4, 1'b1);

        // 6: reset in digit 2 with a pending shadow value
        goto(226); pulse_load(16'hBEEF);
        goto(242); check3("pre_rst",  4'b1011, 4'h2, 1'b0);
        reset = 1'b1;
        step(1);
        check3("in_rst", 4'b1111, 4'h0, 1'b0);
        reset = 1'b0;
        cyc   = 0;
        goto(2);  check3("rst2_d0",  4'b1110, 4'h0, 1'b0);
        goto(32); check3("rst2_fd",  4'b1111, 4'h0, 1'b1);
        goto(42); check3("rst2_d1",  4'b1101, 4'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
